// File: rtl/multi_button_debouncer_pkg.sv
// Shared definitions for the multi-channel push-button debouncer.
//   btn_state_t : per-channel debounce state (2-bit encoding)
//   width_of()  : counter width for a given value count, never below 1 bit
package multi_button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE0 = 2'd0,  // debounced low, input low
    WAIT1 = 2'd1,  // debounced low, input high, qualifying
    HIGH  = 2'd2,  // debounced high, input high
    WAIT0 = 2'd3   // debounced high, input low, qualifying
  } btn_state_t;

  function automatic int width_of(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, stability counter
// and long-press hold counter. Sample ticks come from a shared prescaler.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   btn_in         raw button input (1 = pressed)
//   tick           shared sample tick, one clk cycle wide
//   level          debounced level
//   press          1-cycle pulse on accepted 0->1
//   released       1-cycle pulse on accepted 1->0
//   long_press     1-cycle pulse once per hold after LONG_TICKS ticks high
module debounce_channel
  import multi_button_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic tick,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press
);

  localparam int CW = width_of(STABLE_TICKS + 1);
  localparam int HW = width_of(LONG_TICKS + 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(STABLE_TICKS);
  localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_TICKS);

  logic          sync_meta;
  logic          sync_s;
  btn_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic          level_n, press_n, released_n, long_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_s    <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE0;
      cnt        <= '0;
      hold       <= '0;
      level      <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      level      <= level_n;
      press      <= press_n;
      released   <= released_n;
      long_press <= long_n;
    end
  end

  // An input change always wins over a tick in the same cycle: the change
  // branch is tested first and the tick is simply not counted.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    hold_n     = hold;
    level_n    = level;
    press_n    = 1'b0;
    released_n = 1'b0;
    long_n     = 1'b0;
    case (state)
      IDLE0: begin
        if (sync_s) begin
          state_n = WAIT1;
          cnt_n   = '0;
        end
      end
      WAIT1: begin
        if (!sync_s) begin
          state_n = IDLE0;
        end else if (tick) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == CNT_DONE) begin
            state_n = HIGH;
            level_n = 1'b1;
            press_n = 1'b1;
            hold_n  = '0;
          end
        end
      end
      HIGH: begin
        if (!sync_s) begin
          state_n = WAIT0;
          cnt_n   = '0;
        end else if (tick && (hold < HOLD_DONE)) begin
          // Saturating hold counter, so long_press fires once per hold.
          hold_n = hold + HW'(1);
          if (hold_n == HOLD_DONE) begin
            long_n = 1'b1;
          end
        end
      end
      WAIT0: begin
        if (sync_s) begin
          // Glitch low: back to HIGH, hold count kept so no second long_press.
          state_n = HIGH;
        end else if (tick) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == CNT_DONE) begin
            state_n    = IDLE0;
            level_n    = 1'b0;
            released_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE0;
      end
    endcase
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer: one shared sample-tick prescaler fanned
// out to N_CH independent debounce channels.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   btn_in       raw button inputs, 1 = pressed
//   level        debounced levels
//   press        1-cycle pulses on accepted 0->1
//   released     1-cycle pulses on accepted 1->0 ("release" is a reserved
//                word in SystemVerilog, hence the name)
//   long_press   1-cycle pulses after LONG_TICKS ticks held high
//   tick         prescaler tick, 1 cycle wide
module multi_button_debouncer
  import multi_button_debouncer_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] long_press,
  output logic            tick
);

  localparam int PW = width_of(TICK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  // With TICK_DIV = 1 the counter sits at 0 and tick stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == DIV_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == DIV_LAST);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in[i]),
      .tick      (tick),
      .level     (level[i]),
      .press     (press[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
module tb_multi_button_debouncer;

  localparam int NC = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] btn_in;
  logic [NC-1:0] level, press, released, long_press;
  logic          tick;

  multi_button_debouncer #(
    .N_CH(NC), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level), .press(press),
    .released(released), .long_press(long_press), .tick(tick)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: works from the rules "level follows the synchronised
  // input once it has stayed at a new value across ST ticks (the tick of the
  // change cycle not counted)" and "long_press once LT ticks have been seen
  // while both debounced and raw-sync input stay high".
  logic          mSync1[NC], mSync2[NC], mPrev[NC], mLvl[NC];
  int            mRun[NC], mHeld[NC];
  int            edgeCount;
  logic [NC-1:0] expLevel, expPress, expRel, expLong;
  logic          expTick;

  logic [NC-1:0] pressSeen, relSeen;
  int            bothCount;

  typedef struct {
    logic [NC-1:0] btn;
    int            cycles;
    logic [NC-1:0] level, press, rel, lng;
    logic          tick;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NC; c++) begin
      mSync1[c] = 1'b0; mSync2[c] = 1'b0; mPrev[c] = 1'b0; mLvl[c] = 1'b0;
      mRun[c] = 0; mHeld[c] = 0;
    end
    edgeCount = 0;
    expLevel = '0; expPress = '0; expRel = '0; expLong = '0; expTick = 1'b0;
  endtask

  task automatic modelEdge();
    logic tickAt;
    logic sv;
    tickAt = ((edgeCount % TD) == TD - 1);
    edgeCount++;
    expPress = '0; expRel = '0; expLong = '0;
    for (int c = 0; c < NC; c++) begin
      sv = mSync2[c];
      mSync2[c] = mSync1[c];
      mSync1[c] = btn_in[c];
      if (sv != mPrev[c]) mRun[c] = 0;
      else if (tickAt) mRun[c]++;
      if (mLvl[c] && sv && mPrev[c] && tickAt && mHeld[c] < LT) begin
        mHeld[c]++;
        if (mHeld[c] == LT) expLong[c] = 1'b1;
      end
      if (sv != mLvl[c] && mRun[c] >= ST) begin
        mLvl[c] = sv;
        if (sv) begin
          expPress[c] = 1'b1;
          mHeld[c] = 0;
        end else begin
          expRel[c] = 1'b1;
        end
      end
      mPrev[c] = sv;
      expLevel[c] = mLvl[c];
    end
    expTick = ((edgeCount % TD) == TD - 1);
  endtask

  // Drive one cycle of input, advance one clock edge, check against model.
  task automatic applyStimulus(input logic [NC-1:0] b);
    btn_in = b;
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput("level", level, expLevel);
    checkOutput("press", press, expPress);
    checkOutput("release", released, expRel);
    checkOutput("long_press", long_press, expLong);
    checkOutput("tick", tick, expTick);
    pressSeen |= press;
    relSeen |= released;
    if (press[0] && press[3]) bothCount++;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " level"}, level, 0);
    checkOutput({name, " press"}, press, 0);
    checkOutput({name, " release"}, released, 0);
    checkOutput({name, " long_press"}, long_press, 0);
    checkOutput({name, " tick"}, tick, 0);
  endtask

  initial begin
    logic [NC-1:0] rb;
    int holdLeft[NC];

    // Idle 39 edges, then channel 2 pressed at edge 40: seen by FSM at 42,
    // ticks at 44/48/52 -> press at 52; hold ticks 56..72 -> long at 72;
    // release input at 74, seen at 76 (tick ignored), ticks 80/84/88.
    vecs[0] = '{4'b0000, 39, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[1] = '{4'b0100, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[2] = '{4'b0100,  1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0};
    vecs[3] = '{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{4'b0100, 18, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[5] = '{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0};
    vecs[6] = '{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[7] = '{4'b0000, 14, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[8] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    vecs[9] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    pressSeen = '0; relSeen = '0; bothCount = 0;
    btn_in = '0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      for (int n = 0; n < vecs[v].cycles; n++) applyStimulus(vecs[v].btn);
      checkOutput($sformatf("vec%0d level", v), level, vecs[v].level);
      checkOutput($sformatf("vec%0d press", v), press, vecs[v].press);
      checkOutput($sformatf("vec%0d release", v), released, vecs[v].rel);
      checkOutput($sformatf("vec%0d long_press", v), long_press, vecs[v].lng);
      checkOutput($sformatf("vec%0d tick", v), tick, vecs[v].tick);
    end

    // Bouncing channel 1: never stable for 3 ticks.
    pressSeen = '0;
    for (int n = 0; n < 60; n++) applyStimulus(((n / 3) % 2 == 0) ? 4'b0010 : 4'b0000);
    for (int n = 0; n < 20; n++) applyStimulus(4'b0000);
    checkOutput("bounce press1", pressSeen[1], 1'b0);
    checkOutput("bounce level1", level[1], 1'b0);

    // Channel 0 high, 2-cycle glitch low, then held low.
    for (int n = 0; n < 20; n++) applyStimulus(4'b0001);
    checkOutput("ch0 level high", level[0], 1'b1);
    relSeen = '0;
    for (int n = 0; n < 2; n++) applyStimulus(4'b0000);
    for (int n = 0; n < 10; n++) applyStimulus(4'b0001);
    checkOutput("glitch no release", relSeen[0], 1'b0);
    checkOutput("glitch level0", level[0], 1'b1);
    for (int n = 0; n < 20; n++) applyStimulus(4'b0000);
    checkOutput("ch0 released", relSeen[0], 1'b1);
    checkOutput("ch0 level low", level[0], 1'b0);

    // Channels 0 and 3 rise together.
    bothCount = 0;
    for (int n = 0; n < 20; n++) applyStimulus(4'b1001);
    checkOutput("simultaneous press", bothCount, 1);
    for (int n = 0; n < 20; n++) applyStimulus(4'b0000);

    // Reset while channel 1 sits in WAIT1, button let go during reset.
    for (int n = 0; n < 4; n++) applyStimulus(4'b0010);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("mid reset");
    btn_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    pressSeen = '0;
    for (int n = 0; n < 30; n++) applyStimulus(4'b0000);
    checkOutput("no press after reset", pressSeen[1], 1'b0);

    // Button held through reset deassertion still produces a press.
    rst = 1'b1;
    btn_in = 4'b0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    pressSeen = '0;
    for (int n = 0; n < 20; n++) applyStimulus(4'b0010);
    checkOutput("held through reset press", pressSeen[1], 1'b1);
    for (int n = 0; n < 20; n++) applyStimulus(4'b0000);

    // Randomised run against the model.
    rb = '0;
    for (int c = 0; c < NC; c++) holdLeft[c] = 1;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NC; c++) begin
        holdLeft[c]--;
        if (holdLeft[c] <= 0) begin
          rb[c] = ~rb[c];
          holdLeft[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                    : int'($urandom_range(1, 6));
        end
      end
      applyStimulus(rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
